// File: rtl/panel_io_ctrl.sv
// Host-panel I/O controller: synchronised/debounced buttons with sticky press flags and
// press counters, plus per-LED static/blink/PWM/button-follow drive. Optional macro:
// PANEL_IO_AUTOREPEAT_EN adds timed auto-repeat press events while a button is held.
module panel_io_ctrl #(
  parameter int N_BTN          = 4,
  parameter int N_LED          = 8,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int DEBOUNCE_CYC   = 20000,
  parameter int TICK_DIV       = 48000,
  parameter int BLINK_TICKS    = 250,
  parameter int REPEAT_DLY     = 500,
  parameter int REPEAT_PER     = 100
) (
  input  logic                 ti_clk,
  input  logic                 rst_n,
  input  logic [N_BTN-1:0]     btn_raw,
  input  logic [N_LED-1:0]     led_val,
  input  logic [2*N_LED-1:0]   led_mode,
  input  logic [7:0]           pwm_duty,
  input  logic [N_BTN-1:0]     evt_clr,
  output logic [N_BTN-1:0]     btn_level,
  output logic [N_BTN-1:0]     btn_evt,
  output logic [8*N_BTN-1:0]   btn_cnt,
  output logic [N_LED-1:0]     led_on
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_BTN    = 2'b11
  } led_mode_e;

  localparam int              DB_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam int              TK_W    = $clog2(TICK_DIV);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
  localparam int              BL_W    = $clog2(BLINK_TICKS + 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  logic [N_BTN-1:0] btn_in, sync1, sync2, level_d, rise, set;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [TK_W-1:0]  presc;
  logic             tick;
  logic [BL_W-1:0]  blink_cnt;
  logic             blink_phase;
  logic [7:0]       pwm_cnt;
  logic             pwm_on;

  // Normalise polarity so everything downstream sees 1 = pressed.
  assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-button counter array is plain flops, so it is reset element by element.
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
      btn_level <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i] <= sync2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = btn_level & ~level_d;

`ifdef PANEL_IO_AUTOREPEAT_EN
  localparam int              RP_MAX      = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int              RP_W        = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] RP_DLY_LAST = RP_W'(REPEAT_DLY - 1);
  localparam logic [RP_W-1:0] RP_PER_LAST = RP_W'(REPEAT_PER - 1);

  logic [RP_W-1:0]  rp_cnt [N_BTN];
  logic [N_BTN-1:0] rp_armed, rp_pulse;

  // Ticks counted while held: first repeat after REPEAT_DLY, then every REPEAT_PER.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) rp_cnt[i] <= '0;
      rp_armed <= '0;
      rp_pulse <= '0;
    end else begin
      rp_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn_level[i]) begin
          rp_cnt[i]   <= '0;
          rp_armed[i] <= 1'b0;
        end else if (tick) begin
          if (rp_cnt[i] == (rp_armed[i] ? RP_PER_LAST : RP_DLY_LAST)) begin
            rp_pulse[i] <= 1'b1;
            rp_armed[i] <= 1'b1;
            rp_cnt[i]   <= '0;
          end else begin
            rp_cnt[i] <= rp_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign set = rise | rp_pulse;
`else
  assign set = rise;
`endif

  // A set in the same cycle as a clear leaves the flag set.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= '0;
      btn_evt <= '0;
      btn_cnt <= '0;
    end else begin
      level_d <= btn_level;
      btn_evt <= set | (btn_evt & ~evt_clr);
      for (int i = 0; i < N_BTN; i++) begin
        if (set[i]) btn_cnt[8*i +: 8] <= btn_cnt[8*i +: 8] + 8'd1;
      end
    end
  end

  assign tick = (presc == TK_LAST);

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
      if (tick) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Counter spans 0..254, so duty 255 is always on and duty 0 never is.
  assign pwm_on = (pwm_cnt < pwm_duty);

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      led_on <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        case (led_mode_e'(led_mode[2*i +: 2]))
          MODE_STATIC: led_on[i] <= led_val[i];
          MODE_BLINK:  led_on[i] <= led_val[i] & blink_phase;
          MODE_PWM:    led_on[i] <= led_val[i] & pwm_on;
          MODE_BTN:    led_on[i] <= btn_level[i % N_BTN];
          default:     led_on[i] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_panel_io_ctrl.sv
// Self-checking bench for panel_io_ctrl: table-driven LED vectors through a scoreboard queue,
// plus hand-written debounce, counter-wrap, clear, PWM, blink and hold/auto-repeat sequences.
module tb_panel_io_ctrl;

  localparam int N_BTN = 4;
  localparam int N_LED = 8;
  localparam int DEB   = 4;
  localparam int TDIV  = 2;
  localparam int BLT   = 3;
  localparam int RDLY  = 5;
  localparam int RPER  = 2;

  logic               ti_clk = 1'b0;
  logic               rst_n  = 1'b0;
  logic [N_BTN-1:0]   btn_raw;
  logic [N_LED-1:0]   led_val;
  logic [2*N_LED-1:0] led_mode;
  logic [7:0]         pwm_duty;
  logic [N_BTN-1:0]   evt_clr;
  logic [N_BTN-1:0]   btn_level;
  logic [N_BTN-1:0]   btn_evt;
  logic [8*N_BTN-1:0] btn_cnt;
  logic [N_LED-1:0]   led_on;

  panel_io_ctrl #(
    .N_BTN(N_BTN), .N_LED(N_LED), .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYC(DEB),
    .TICK_DIV(TDIV), .BLINK_TICKS(BLT), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
  ) dut (
    .ti_clk(ti_clk), .rst_n(rst_n), .btn_raw(btn_raw), .led_val(led_val),
    .led_mode(led_mode), .pwm_duty(pwm_duty), .evt_clr(evt_clr),
    .btn_level(btn_level), .btn_evt(btn_evt), .btn_cnt(btn_cnt), .led_on(led_on)
  );

  always #5 ti_clk = ~ti_clk;

  typedef struct {
    logic [15:0] mode;
    logic [7:0]  val;
    logic [7:0]  duty;
    logic [7:0]  exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_cnt [N_BTN];
  logic [7:0]  sb_q [$];
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n active edges, then settle 1 time unit away from the edge.
  task automatic step(input int n);
    repeat (n) @(posedge ti_clk);
    #1;
  endtask

  function automatic logic [7:0] cnt_of(input int i);
    return btn_cnt[8*i +: 8];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_v;
    logic       prev;
    int         run;
    int         hi;
    bit         found;
    logic [7:0] duties [3];
    logic [7:0] hold_exp;

    vecs[0] = '{mode: 16'h0000, val: 8'hA5, duty: 8'd0,   exp: 8'hA5};
    vecs[1] = '{mode: 16'h0000, val: 8'h5A, duty: 8'd0,   exp: 8'h5A};
    vecs[2] = '{mode: 16'hAAAA, val: 8'hFF, duty: 8'd0,   exp: 8'h00};
    vecs[3] = '{mode: 16'hAAAA, val: 8'h3C, duty: 8'd255, exp: 8'h3C};
    vecs[4] = '{mode: 16'hFFFF, val: 8'hFF, duty: 8'd255, exp: 8'h00};
    vecs[5] = '{mode: 16'hAA00, val: 8'h96, duty: 8'd255, exp: 8'h96};
    vecs[6] = '{mode: 16'h5555, val: 8'h00, duty: 8'd128, exp: 8'h00};
    duties[0] = 8'd64; duties[1] = 8'd0; duties[2] = 8'd255;
    for (int i = 0; i < N_BTN; i++) exp_cnt[i] = 8'd0;

    // Reset held with buttons toggling and an LED request pending.
    btn_raw = 4'hF; led_val = 8'hFF; led_mode = '0; pwm_duty = 8'd0; evt_clr = '0;
    for (int i = 0; i < 5; i++) begin
      btn_raw = ~btn_raw;
      step(1);
    end
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_evt",   32'(btn_evt),   32'h0);
    check("rst_cnt",   btn_cnt,        32'h0);
    check("rst_led",   32'(led_on),    32'h0);

    // Release with btn 3 already pressed: level must wait DEB+2 edges.
    btn_raw = 4'b0111; led_val = 8'h00; rst_n = 1'b1;
    step(DEB + 1);
    check("post_rst_hold", 32'(btn_level), 32'h0);
    step(1);
    check("post_rst_level", 32'(btn_level), 32'h8);
    step(1);
    exp_cnt[3]++;
    check("post_rst_evt", 32'(btn_evt), 32'h8);
    check("post_rst_cnt3", 32'(cnt_of(3)), 32'(exp_cnt[3]));
    btn_raw = 4'hF;
    step(8);
    check("release_no_evt", 32'(cnt_of(3)), 32'(exp_cnt[3]));
    evt_clr = 4'b1000;
    step(1);
    evt_clr = '0;
    check("clear_evt3", 32'(btn_evt), 32'h0);

    // Glitch of DEB-1 cycles is ignored.
    btn_raw[0] = 1'b0;
    step(DEB - 1);
    btn_raw[0] = 1'b1;
    step(8);
    check("glitch_level", 32'(btn_level), 32'h0);
    check("glitch_cnt0",  32'(cnt_of(0)), 32'h0);

    // Clean 10-cycle press: level at edge 6, event/count at edge 7.
    btn_raw[0] = 1'b0;
    step(5);
    check("deb_edge5", 32'(btn_level[0]), 32'h0);
    step(1);
    check("deb_edge6", 32'(btn_level[0]), 32'h1);
    check("deb_evt_e6", 32'(btn_evt[0]), 32'h0);
    step(1);
    exp_cnt[0]++;
    check("deb_evt_e7", 32'(btn_evt[0]), 32'h1);
    check("deb_cnt_e7", 32'(cnt_of(0)), 32'(exp_cnt[0]));
    step(3);
    btn_raw[0] = 1'b1;
    step(8);
    check("deb_release", 32'(btn_level[0]), 32'h0);

    // 256 presses on btn 2 wrap its counter back to 0.
    for (int i = 0; i < 256; i++) begin
      btn_raw[2] = 1'b0;
      step(8);
      btn_raw[2] = 1'b1;
      step(8);
      exp_cnt[2]++;
      if (i == 254) check("wrap_255", 32'(cnt_of(2)), 32'(exp_cnt[2]));
    end
    check("wrap_0", 32'(cnt_of(2)), 32'(exp_cnt[2]));
    check("wrap_evt", 32'(btn_evt[2]), 32'h1);
    evt_clr = 4'b0100;
    step(1);
    evt_clr = '0;
    check("clear_evt2", 32'(btn_evt[2]), 32'h0);
    btn_raw[2] = 1'b0;
    step(DEB + 2);
    evt_clr = 4'b0100;
    step(1);
    evt_clr = '0;
    exp_cnt[2]++;
    check("set_beats_clr", 32'(btn_evt), 32'h5);
    check("set_clr_cnt2", 32'(cnt_of(2)), 32'(exp_cnt[2]));
    btn_raw[2] = 1'b1;
    step(8);

    // Table vectors through the scoreboard, one registered cycle each.
    for (int i = 0; i < 7; i++) begin
      led_mode = vecs[i].mode; led_val = vecs[i].val; pwm_duty = vecs[i].duty;
      sb_q.push_back(vecs[i].exp);
      step(1);
      exp_v = sb_q.pop_front();
      check($sformatf("vec%0d", i), 32'(led_on), 32'(exp_v));
    end

    // PWM high count over one full period.
    led_mode = 16'hAAAA; led_val = 8'hFF;
    for (int d = 0; d < 3; d++) begin
      pwm_duty = duties[d];
      step(2);
      hi = 0;
      for (int c = 0; c < 255; c++) begin
        step(1);
        if (led_on[0]) hi++;
      end
      check($sformatf("pwm_duty_%0d", duties[d]), 32'(hi), 32'(duties[d]));
    end

    // Blink: half-period TDIV*BLT cycles.
    led_mode = 16'h5555; led_val = 8'h01;
    step(1);
    for (int r = 0; r < 2; r++) begin
      prev = led_on[0];
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        step(1);
        if (led_on[0] !== prev) found = 1'b1;
      end
      check("blink_found", 32'(found), 32'h1);
      prev = led_on[0];
      run = 0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        step(1);
        run++;
        if (led_on[0] !== prev) found = 1'b1;
      end
      check("blink_period", 32'(run), 32'(TDIV * BLT));
    end
    check("blink_val0_dark", 32'(led_on[7:1]), 32'h0);

    // LED 5 follows btn_level[1]; hold btn 1 for 80 cycles (40 ticks).
    led_mode = 16'h0C00; led_val = 8'h00;
    step(2);
    btn_raw[1] = 1'b0;
    step(DEB + 2);
    check("follow_level", 32'(btn_level[1]), 32'h1);
    check("follow_pre", 32'(led_on[5]), 32'h0);
    step(1);
    exp_cnt[1]++;
    check("follow_on", 32'(led_on[5]), 32'h1);
    check("hold_first", 32'(cnt_of(1)), 32'(exp_cnt[1]));
    step(73);
    btn_raw[1] = 1'b1;
    step(DEB + 2);
    check("hold_release", 32'(btn_level[1]), 32'h0);
    step(1);
    check("follow_off", 32'(led_on[5]), 32'h0);
    step(5);
`ifdef PANEL_IO_AUTOREPEAT_EN
    hold_exp = 8'd1 + 8'd1 + 8'((40 - RDLY) / RPER);
`else
    hold_exp = 8'd1;
`endif
    check("hold_cnt1", 32'(cnt_of(1)), 32'(hold_exp));
    check("other_cnt0", 32'(cnt_of(0)), 32'(exp_cnt[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
